// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and maximal-length tap tables for the LFSR family.
package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } fsm_t;

    // Fibonacci form: bit i set means state bit i feeds the XOR into bit 0.
    function automatic logic [31:0] fibTaps(input int width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            17:      return 32'h0001_2000;
            18:      return 32'h0002_0400;
            19:      return 32'h0004_0023;
            20:      return 32'h0009_0000;
            21:      return 32'h0014_0000;
            22:      return 32'h0030_0000;
            23:      return 32'h0042_0000;
            24:      return 32'h00E1_0000;
            25:      return 32'h0120_0000;
            26:      return 32'h0200_0023;
            27:      return 32'h0400_0013;
            28:      return 32'h0900_0000;
            29:      return 32'h1400_0000;
            30:      return 32'h2000_0029;
            31:      return 32'h4800_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Galois form: the feedback polynomial without its x^WIDTH term.
    function automatic logic [31:0] galTaps(input int width);
        case (width)
            4:       return 32'h0000_0009;
            5:       return 32'h0000_0009;
            6:       return 32'h0000_0021;
            7:       return 32'h0000_0041;
            8:       return 32'h0000_0071;
            9:       return 32'h0000_0021;
            10:      return 32'h0000_0081;
            11:      return 32'h0000_0201;
            12:      return 32'h0000_0053;
            13:      return 32'h0000_001B;
            14:      return 32'h0000_002B;
            15:      return 32'h0000_4001;
            16:      return 32'h0000_A011;
            17:      return 32'h0000_4001;
            18:      return 32'h0000_0801;
            19:      return 32'h0000_0047;
            20:      return 32'h0002_0001;
            21:      return 32'h0008_0001;
            22:      return 32'h0020_0001;
            23:      return 32'h0004_0001;
            24:      return 32'h00C2_0001;
            25:      return 32'h0040_0001;
            26:      return 32'h0000_0047;
            27:      return 32'h0000_0027;
            28:      return 32'h0200_0001;
            29:      return 32'h0800_0001;
            30:      return 32'h0000_0053;
            31:      return 32'h1000_0001;
            32:      return 32'h0040_0007;
            default: return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Purely combinational LFSR next-state function, shared by the generator and the PRBS checker.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    if (MODE == MODE_GAL) begin : g_galois
        assign o_next = {i_state[WIDTH-2:0], 1'b0} ^ ({WIDTH{i_state[WIDTH-1]}} & TAPS);
    end else begin : g_fibonacci
        assign o_next = {i_state[WIDTH-2:0], ^(i_state & TAPS)};
    end

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Parametrised LFSR PRBS generator with seed load, free-run/burst stepping,
// all-zero lock-up recovery and period measurement.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter int               MODE  = MODE_FIB,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             ckIn,
    input  logic             rstN,
    input  logic             ckEn,
    input  logic             loadStb,
    input  logic [WIDTH-1:0] seedIn,
    input  logic             burstGo,
    input  logic [WIDTH-1:0] burstLen,
    output logic             busy,
    output logic             burstDone,
    output logic             out,
    output logic [WIDTH-1:0] state,
    output logic             wrapStb,
    output logic [WIDTH-1:0] periodOut,
    output logic             lockErr
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fsm_t             r_fsm;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_seed;
    logic [WIDTH-1:0] r_stepCnt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_remaining;
    logic             r_busy;
    logic             r_burstDone;
    logic             r_wrapStb;
    logic             r_lockErr;

    logic [WIDTH-1:0] w_next;
    logic             w_stepReq;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next (
        .i_state (r_state),
        .o_next  (w_next)
    );

    // A burst steps every cycle regardless of ckEn.
    assign w_stepReq = (r_fsm == BURST) || ckEn;

    always_ff @(posedge ckIn or negedge rstN) begin
        if (!rstN) begin
            r_fsm       <= IDLE;
            r_state     <= SEED;
            r_seed      <= SEED;
            r_stepCnt   <= '0;
            r_period    <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_burstDone <= 1'b0;
            r_wrapStb   <= 1'b0;
            r_lockErr   <= 1'b0;
        end else begin
            r_burstDone <= 1'b0;
            r_wrapStb   <= 1'b0;
            r_lockErr   <= 1'b0;

            // A seed load wins over everything, including a burstGo in the same cycle.
            if (loadStb) begin
                r_state     <= seedIn;
                r_seed      <= seedIn;
                r_stepCnt   <= '0;
                r_fsm       <= IDLE;
                r_busy      <= 1'b0;
                r_remaining <= '0;
            end else begin
                case (r_fsm)
                    IDLE: begin
                        if (burstGo) begin
                            if (burstLen != '0) begin
                                r_fsm       <= BURST;
                                r_busy      <= 1'b1;
                                r_remaining <= burstLen;
                            end else begin
                                r_burstDone <= 1'b1;
                            end
                        end
                    end
                    BURST: begin
                        r_remaining <= r_remaining - ONE;
                        if (r_remaining == ONE) begin
                            r_fsm       <= IDLE;
                            r_busy      <= 1'b0;
                            r_burstDone <= 1'b1;
                        end
                    end
                    default: r_fsm <= IDLE;
                endcase

                if (w_stepReq) begin
                    if (r_state == '0) begin
                        r_state   <= SEED;
                        r_seed    <= SEED;
                        r_stepCnt <= '0;
                        r_lockErr <= 1'b1;
                    end else begin
                        r_state <= w_next;
                        if (w_next == r_seed) begin
                            r_period  <= r_stepCnt + ONE;
                            r_stepCnt <= '0;
                            r_wrapStb <= 1'b1;
                        end else begin
                            r_stepCnt <= r_stepCnt + ONE;
                        end
                    end
                end
            end
        end
    end

    assign state     = r_state;
    assign out       = r_state[WIDTH-1];
    assign busy      = r_busy;
    assign burstDone = r_burstDone;
    assign wrapStb   = r_wrapStb;
    assign periodOut = r_period;
    assign lockErr   = r_lockErr;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Bench for lfsr_prbs_gen: a Fibonacci (default) and a Galois (taps 0x1D) instance share
// one stimulus stream and are compared each cycle against a behavioural model.
module tb_lfsr_prbs_gen;

    logic       ckIn = 1'b0;
    logic       rstN;
    logic       ckEn;
    logic       loadStb;
    logic [7:0] seedIn;
    logic       burstGo;
    logic [7:0] burstLen;

    logic       busyF, doneF, outF, wrapF, lockF;
    logic [7:0] stateF, periodF;
    logic       busyG, doneG, outG, wrapG, lockG;
    logic [7:0] stateG, periodG;

    int tests  = 0;
    int failed = 0;

    // Behavioural model: index 0 = Fibonacci/0xB8, index 1 = Galois/0x1D.
    logic [7:0] mState[2];
    logic [7:0] mSeed[2];
    int         mCnt[2];
    int         mPeriod[2];
    bit         mWrap[2];
    bit         mLock[2];
    bit         mInBurst;
    int         mRemain;
    bit         mDone;

    always #5 ckIn = ~ckIn;

    lfsr_prbs_gen dutF (
        .ckIn(ckIn), .rstN(rstN), .ckEn(ckEn), .loadStb(loadStb), .seedIn(seedIn),
        .burstGo(burstGo), .burstLen(burstLen), .busy(busyF), .burstDone(doneF),
        .out(outF), .state(stateF), .wrapStb(wrapF), .periodOut(periodF), .lockErr(lockF)
    );

    lfsr_prbs_gen #(.WIDTH(8), .TAPS(8'h1D), .MODE(1), .SEED(8'h01)) dutG (
        .ckIn(ckIn), .rstN(rstN), .ckEn(ckEn), .loadStb(loadStb), .seedIn(seedIn),
        .burstGo(burstGo), .burstLen(burstLen), .busy(busyG), .burstDone(doneG),
        .out(outG), .state(stateG), .wrapStb(wrapG), .periodOut(periodG), .lockErr(lockG)
    );

    function automatic logic [7:0] nextOf(input int m, input logic [7:0] s);
        int v;
        v = (int'(s) * 2) % 256;
        if (m == 0) v = v + ($countones(s & 8'hB8) % 2);
        else if (s >= 8'd128) v = v ^ 'h1D;
        return 8'(v);
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mState[m] = 8'h01; mSeed[m] = 8'h01; mCnt[m] = 0; mPeriod[m] = 0;
            mWrap[m] = 0; mLock[m] = 0;
        end
        mInBurst = 0; mRemain = 0; mDone = 0;
    endtask

    task automatic modelEdge(input bit ck, input bit ld, input logic [7:0] sd,
                             input bit go, input int len);
        bit step;
        logic [7:0] n;
        mDone = 0;
        for (int m = 0; m < 2; m++) begin mWrap[m] = 0; mLock[m] = 0; end
        if (ld) begin
            for (int m = 0; m < 2; m++) begin mState[m] = sd; mSeed[m] = sd; mCnt[m] = 0; end
            mInBurst = 0; mRemain = 0;
        end else begin
            step = mInBurst || ck;
            if (!mInBurst) begin
                if (go && len != 0) begin mInBurst = 1; mRemain = len; end
                else if (go) mDone = 1;
            end else begin
                mRemain = mRemain - 1;
                if (mRemain == 0) begin mInBurst = 0; mDone = 1; end
            end
            if (step) begin
                for (int m = 0; m < 2; m++) begin
                    if (mState[m] == 8'h00) begin
                        mState[m] = 8'h01; mSeed[m] = 8'h01; mCnt[m] = 0; mLock[m] = 1;
                    end else begin
                        n = nextOf(m, mState[m]);
                        mState[m] = n;
                        if (n == mSeed[m]) begin
                            mPeriod[m] = (mCnt[m] + 1) % 256; mCnt[m] = 0; mWrap[m] = 1;
                        end else begin
                            mCnt[m] = (mCnt[m] + 1) % 256;
                        end
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit ck, input bit ld, input logic [7:0] sd,
                                 input bit go, input logic [7:0] len);
        ckEn = ck; loadStb = ld; seedIn = sd; burstGo = go; burstLen = len;
        modelEdge(ck, ld, sd, go, int'(len));
        @(posedge ckIn);
        #1;
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkOne({tag, ".F.state"},  32'(stateF),  32'(mState[0]));
        checkOne({tag, ".F.out"},    32'(outF),    32'(mState[0][7]));
        checkOne({tag, ".F.period"}, 32'(periodF), 32'(mPeriod[0]));
        checkOne({tag, ".F.wrap"},   32'(wrapF),   32'(mWrap[0]));
        checkOne({tag, ".F.lock"},   32'(lockF),   32'(mLock[0]));
        checkOne({tag, ".F.busy"},   32'(busyF),   32'(mInBurst));
        checkOne({tag, ".F.done"},   32'(doneF),   32'(mDone));
        checkOne({tag, ".G.state"},  32'(stateG),  32'(mState[1]));
        checkOne({tag, ".G.out"},    32'(outG),    32'(mState[1][7]));
        checkOne({tag, ".G.period"}, 32'(periodG), 32'(mPeriod[1]));
        checkOne({tag, ".G.wrap"},   32'(wrapG),   32'(mWrap[1]));
        checkOne({tag, ".G.lock"},   32'(lockG),   32'(mLock[1]));
        checkOne({tag, ".G.busy"},   32'(busyG),   32'(mInBurst));
        checkOne({tag, ".G.done"},   32'(doneG),   32'(mDone));
    endtask

    initial begin
        logic [7:0] fibSeq[4];
        int  steps;
        bit  seen;
        fibSeq = '{8'h02, 8'h04, 8'h08, 8'h11};

        rstN = 1'b0; ckEn = 0; loadStb = 0; seedIn = 0; burstGo = 0; burstLen = 0;
        modelReset();
        #12;
        checkOne("rst.state", 32'(stateF), 32'h01);
        checkOne("rst.out", 32'(outF), 32'h0);
        checkOne("rst.period", 32'(periodF), 32'h0);
        checkOutput("rst");
        @(posedge ckIn); #1;
        rstN = 1'b1;

        // Free-run Fibonacci sequence from the reset seed.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 8'h00);
            checkOne("fib.seq", 32'(stateF), 32'(fibSeq[i]));
            checkOne("fib.out", 32'(outF), 32'h0);
            checkOutput("seq");
        end

        // Run on until the first wrap; both tap sets are maximal length.
        steps = 4;
        seen  = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            applyStimulus(1, 0, 8'h00, 0, 8'h00);
            steps++;
            checkOutput("run");
            if (wrapF === 1'b1) seen = 1;
        end
        checkOne("wrap.seen", 32'(seen), 32'h1);
        checkOne("wrap.step", 32'(steps), 32'd255);
        checkOne("wrap.F.period", 32'(periodF), 32'hFF);
        checkOne("wrap.F.state", 32'(stateF), 32'h01);
        checkOne("wrap.G.period", 32'(periodG), 32'hFF);
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOne("wrap.pulse", 32'(wrapF), 32'h0);
        checkOutput("wrapEnd");

        // Galois step from 0x80.
        applyStimulus(0, 1, 8'h80, 0, 8'h00);
        checkOutput("galLoad");
        applyStimulus(1, 0, 8'h00, 0, 8'h00);
        checkOne("gal.step", 32'(stateG), 32'h1D);
        checkOutput("galStep");

        // All-zero seed: no step while ckEn low, recovery on the first step.
        applyStimulus(0, 1, 8'h00, 0, 8'h00);
        checkOutput("zeroLoad");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00);
            checkOne("zero.hold", 32'(stateF), 32'h00);
            checkOutput("zeroHold");
        end
        applyStimulus(1, 0, 8'h00, 0, 8'h00);
        checkOne("lock.state", 32'(stateF), 32'h01);
        checkOne("lock.pulse", 32'(lockF), 32'h1);
        checkOutput("lock");

        // Burst of 3 with ckEn low.
        applyStimulus(0, 0, 8'h00, 1, 8'd3);
        checkOne("burst.busy0", 32'(busyF), 32'h1);
        checkOutput("burst");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 8'h00, 0, 8'h00);
            checkOutput("burst");
        end
        checkOne("burst.state", 32'(stateF), 32'h08);
        checkOne("burst.done", 32'(doneF), 32'h1);
        checkOne("burst.idle", 32'(busyF), 32'h0);
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOne("burst.doneClr", 32'(doneF), 32'h0);
        applyStimulus(0, 0, 8'h00, 1, 8'd0);
        checkOne("burst0.done", 32'(doneF), 32'h1);
        checkOne("burst0.state", 32'(stateF), 32'h08);
        checkOutput("burst0");

        // Seed load aborts a burst.
        applyStimulus(0, 0, 8'h00, 1, 8'd5);
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOutput("abort");
        applyStimulus(0, 1, 8'h5A, 0, 8'h00);
        checkOne("abort.state", 32'(stateF), 32'h5A);
        checkOne("abort.busy", 32'(busyF), 32'h0);
        checkOutput("abort");
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOne("abort.noDone", 32'(doneF), 32'h0);
        checkOutput("abort");

        // Asynchronous reset mid-burst.
        applyStimulus(0, 0, 8'h00, 1, 8'd5);
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        #2 rstN = 1'b0;
        #1;
        modelReset();
        checkOne("arst.state", 32'(stateF), 32'h01);
        checkOne("arst.busy", 32'(busyF), 32'h0);
        checkOutput("arst");
        @(negedge ckIn);
        rstN = 1'b1;
        applyStimulus(0, 0, 8'h00, 0, 8'h00);
        checkOutput("arstRel");

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit         ck, ld, go;
            logic [7:0] sd, len;
            ck  = ($urandom % 4) != 0;
            ld  = ($urandom % 40) == 0;
            sd  = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
            go  = ($urandom % 12) == 0;
            len = 8'($urandom % 7);
            applyStimulus(ck, ld, sd, go, len);
            checkOutput("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_gen.md
Name: lfsr_prbs_gen

Overview:
Parametrised LFSR pseudo-random sequence generator, the successor to the fixed LFSR cell chain. Supports configurable width, tap mask and Fibonacci/Galois mode. Adds seed load, free-run and counted-burst stepping, all-zero lock-up recovery, and sequence-period measurement. Feeds PRBS test patterns and scramblers in the LFSR lab designs.

Parameters:
WIDTH, 8, state register width in bits, 3..32
TAPS, 8'hB8, XOR tap mask of WIDTH bits; bit i set = state bit i participates
MODE, 0, 0 = Fibonacci (external XOR), 1 = Galois (internal XOR)
SEED, 8'h01, reset seed and lock-up recovery value; must be non-zero

Ports:
ckIn  input  1  clock, rising edge
rstN  input  1  asynchronous active-low reset
ckEn  input  1  free-run step enable, one step per cycle while high in IDLE
loadStb  input  1  single-cycle seed load strobe
seedIn  input  WIDTH  seed value captured on loadStb
burstGo  input  1  single-cycle strobe starting a counted burst
burstLen  input  WIDTH  burst step count, captured on burstGo
busy  output  1  high while in BURST
burstDone  output  1  one-cycle pulse after the final burst step
out  output  1  serial output = state[WIDTH-1]
state  output  WIDTH  current LFSR register
wrapStb  output  1  one-cycle pulse when a step returns state to the active seed
periodOut  output  WIDTH  step count of the last completed period
lockErr  output  1  one-cycle pulse when all-zero state is recovered

Behaviour:
- Reset (rstN low, async): state=SEED, active seed=SEED, stepCnt=0, periodOut=0, FSM=IDLE; busy, burstDone, wrapStb, lockErr=0; out=SEED[WIDTH-1].
- Next-state function:
  - Fibonacci: fb = ^(state & TAPS); next = {state[WIDTH-2:0], fb}.
  - Galois: m = state[WIDTH-1]; next = {state[WIDTH-2:0],1'b0} ^ ({WIDTH{m}} & TAPS).
- A step updates state at the rising edge. out and state are direct register outputs, so a step is visible one cycle later. No combinational input-to-output paths.
- FSM IDLE: step when ckEn=1. burstGo with burstLen!=0 -> BURST with remaining=burstLen. burstGo with burstLen=0 -> stay IDLE and pulse burstDone next cycle.
- FSM BURST: busy=1; step every cycle regardless of ckEn; remaining decrements. The step that makes remaining reach 0 returns to IDLE and pulses burstDone the following cycle. burstGo is ignored in BURST.
- Per-cycle priority: loadStb > lock-up recovery > step.
- loadStb: state<=seedIn, active seed<=seedIn, stepCnt<=0, no step that cycle. In BURST, the burst aborts -> IDLE with no burstDone.
- Lock-up: if state==0 in a cycle where a step would occur, state<=SEED, active seed<=SEED, stepCnt<=0, and lockErr pulses. This counts as the step and burst remaining decrements.
- Period: each normal step increments stepCnt (WIDTH bits, modulo 2^WIDTH). If next==active seed: periodOut<=stepCnt+1, stepCnt<=0, wrapStb pulses in the cycle after that edge. A non-invertible TAPS may never wrap; the counter then rolls over silently.
- All strobe outputs are registered one-cycle pulses.

Decomposition:
- Package lfsr_pkg: MODE_FIB/MODE_GAL constants; FSM state enum {IDLE, BURST}; maximal-length default tap constants for widths 4..32 (Fibonacci and Galois forms).
- Sub-module lfsr_next: purely combinational next-state function (WIDTH, TAPS, MODE). Reused by the planned PRBS checker.

Test Plan:
- Reset, MODE=0, defaults, ckEn=1 -> state 0x01,0x02,0x04,0x08,0x11 on successive cycles; out=0 throughout.
- MODE=0, ckEn=1 for 255 steps from reset -> wrapStb once after step 255, periodOut=0xFF, state=0x01.
- MODE=1, TAPS=8'h1D, load 0x80, one step -> state=0x1D; from 0x01 the period measures 0xFF.
- loadStb seedIn=0x00 then ckEn=1 -> next edge state=0x01, lockErr pulse, stepCnt=0; no step while ckEn=0.
- MODE=0, state 0x01, burstGo burstLen=3, ckEn=0 -> busy for 3 cycles, state ends 0x08, burstDone 1 cycle; burstLen=0 -> burstDone only, state unchanged.
- Mid-burst loadStb seedIn=0x5A -> state=0x5A, busy=0 next cycle, no burstDone. rstN low mid-burst -> immediate state=0x01, busy=0.
